// File: rtl/rr_req_master_if.sv
// Job, request/grant and transfer signals between rr_req_master, its clients and the arbiter.
// The master modport is the requester agent; the slave modport is its environment.
interface rr_req_master_if #(
    parameter int N = 8
);
    localparam int CH_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    job_push;
    logic [N-1:0]    job_full;
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic            xfer_valid;
    logic [CH_W-1:0] xfer_ch;
    logic [7:0]      xfer_beat;
    logic            xfer_last;
    logic [N-1:0]    done;
    logic            err;

    modport master (
        input  job_push,
        input  grant,
        output job_full,
        output req,
        output xfer_valid,
        output xfer_ch,
        output xfer_beat,
        output xfer_last,
        output done,
        output err
    );

    modport slave (
        output job_push,
        output grant,
        input  job_full,
        input  req,
        input  xfer_valid,
        input  xfer_ch,
        input  xfer_beat,
        input  xfer_last,
        input  done,
        input  err
    );
endinterface

// File: rtl/rr_req_master.sv
// Requester agent for a round-robin arbiter: per-client job counters, req generation, fixed bursts.
// Define RR_REQ_MASTER_CHECK_EN to compile in the sticky grant-protocol checker driving err.
module rr_req_master #(
    parameter int N         = 8,
    parameter int CNT_W     = 4,
    parameter int BURST_LEN = 4
) (
    input  logic            clk,
    input  logic            rstn,
    rr_req_master_if.master bus
);
    localparam int               CH_W      = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [7:0]       LAST_BEAT = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [N-1:0]    req_reg;
    logic [N-1:0]    done_reg;
    logic            xfer_valid_reg;
    logic            xfer_last_reg;
    logic [CH_W-1:0] ch_reg;
    logic [7:0]      beat_reg;

    logic [N-1:0]    cnt_nz;
    logic [N-1:0]    full_vec;
    logic [CH_W-1:0] grant_idx;
    logic            grant_any;
    logic            grant_take;
    logic            xfer_end;

    assign xfer_end = (state_reg == XFER) && (beat_reg == LAST_BEAT);

    // Push and completion on the same edge cancel; a push into a full counter is dropped.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_client
            logic [CNT_W-1:0] cnt_reg;
            logic             push_ok;
            logic             cmpl;

            assign push_ok      = bus.job_push[gi] && (cnt_reg != CNT_MAX);
            assign cmpl         = xfer_end && (ch_reg == CH_W'(gi));
            assign cnt_nz[gi]   = (cnt_reg != '0);
            assign full_vec[gi] = (cnt_reg == CNT_MAX);

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    cnt_reg <= '0;
                end else if (push_ok && !cmpl) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end else if (!push_ok && cmpl) begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end
        end
    endgenerate

    // Lowest set grant bit wins when several are present.
    always_comb begin
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.grant[i]) begin
                grant_idx = CH_W'(i);
            end
        end
    end

    assign grant_any = |bus.grant;

`ifdef RR_REQ_MASTER_CHECK_EN
    logic grant_onehot;
    logic grant_bad;
    logic err_reg;

    assign grant_onehot = grant_any && ((bus.grant & (bus.grant - N'(1))) == '0);
    assign grant_take   = grant_onehot && cnt_nz[grant_idx];
    assign grant_bad    = grant_any &&
                          (!grant_onehot || (|(bus.grant & ~req_reg)) || (|(bus.grant & ~cnt_nz)));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_reg <= 1'b0;
        end else if ((state_reg == IDLE) && grant_bad) begin
            err_reg <= 1'b1;
        end
    end

    assign bus.err = err_reg;
`else
    assign grant_take = grant_any && cnt_nz[grant_idx];
    assign bus.err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            req_reg        <= '0;
            done_reg       <= '0;
            xfer_valid_reg <= 1'b0;
            xfer_last_reg  <= 1'b0;
            ch_reg         <= '0;
            beat_reg       <= '0;
        end else begin
            done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (grant_take) begin
                        state_reg      <= XFER;
                        ch_reg         <= grant_idx;
                        req_reg        <= '0;
                        xfer_valid_reg <= 1'b1;
                        beat_reg       <= 8'd0;
                        xfer_last_reg  <= 1'b0;
                    end else begin
                        req_reg <= cnt_nz;
                    end
                end
                XFER: begin
                    if (beat_reg == LAST_BEAT) begin
                        state_reg      <= GAP;
                        xfer_valid_reg <= 1'b0;
                        xfer_last_reg  <= 1'b0;
                        beat_reg       <= 8'd0;
                        done_reg       <= N'(1) << ch_reg;
                    end else begin
                        beat_reg      <= beat_reg + 8'd1;
                        xfer_last_reg <= ((beat_reg + 8'd1) == LAST_BEAT);
                    end
                end
                GAP: begin
                    // Counts already reflect the completed job, so req restarts from fresh state.
                    state_reg <= IDLE;
                    req_reg   <= cnt_nz;
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.req        = req_reg;
    assign bus.done       = done_reg;
    assign bus.job_full   = full_vec;
    assign bus.xfer_valid = xfer_valid_reg;
    assign bus.xfer_last  = xfer_last_reg;
    assign bus.xfer_ch    = ch_reg;
    assign bus.xfer_beat  = beat_reg;
endmodule
